// File: rtl/quad_encoder_gen.sv
// rtl/quad_encoder_gen.sv - quadrature A/B waveform generator driven by step commands
//
// Purpose: emulates a rotary encoder. Each accepted command emits cmd_count
// quadrature edges in one direction, one edge every max(cmd_period,1) clocks,
// and tracks the signed-wrap position of all emitted edges.
//
// Optional feature: define QENC_INDEX_EN to add the enc_z index output.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   cmd_valid    command offered (accepted when cmd_ready is high)
//   cmd_ready    high only in IDLE
//   cmd_dir      1 = forward (position increments), 0 = reverse
//   cmd_count    number of quadrature edges to emit
//   cmd_period   clk cycles between edges (0 behaves as 1)
//   abort        stop the running command; pending edge is suppressed
//   enc_a, enc_b quadrature outputs, straight from flops
//   busy         command in progress
//   done         one-cycle pulse at completion or abort
//   position     emitted-edge count, wraps modulo 2^POS_WIDTH
//   enc_z        (QENC_INDEX_EN only) high while position is zero
module quad_encoder_gen #(
  parameter int CNT_WIDTH = 16,
  parameter int DIV_WIDTH = 16,
  parameter int POS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_dir,
  input  logic [CNT_WIDTH-1:0] cmd_count,
  input  logic [DIV_WIDTH-1:0] cmd_period,
  input  logic                 abort,
  output logic                 enc_a,
  output logic                 enc_b,
  output logic                 busy,
  output logic                 done,
`ifdef QENC_INDEX_EN
  output logic                 enc_z,
`endif
  output logic [POS_WIDTH-1:0] position
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] period_q, period_d;
  logic                 dir_q, dir_d;
  logic                 a_q, a_d;
  logic                 b_q, b_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic                 done_q, done_d;
  // A zero-count command still owes a done pulse one cycle after accept.
  logic                 zero_q, zero_d;
  logic [DIV_WIDTH-1:0] period_eff;

  assign period_eff = (cmd_period == '0) ? DIV_WIDTH'(1) : cmd_period;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    div_d    = div_q;
    period_d = period_q;
    dir_d    = dir_q;
    a_d      = a_q;
    b_d      = b_q;
    pos_d    = pos_q;
    done_d   = 1'b0;
    zero_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (zero_q) done_d = 1'b1;
        if (cmd_valid) begin
          dir_d    = cmd_dir;
          period_d = period_eff;
          div_d    = period_eff - DIV_WIDTH'(1);
          rem_d    = cmd_count;
          if (cmd_count == '0) zero_d = 1'b1;
          else                 state_d = RUN;
        end
      end
      RUN: begin
        // rem_q == 0 marks the done cycle; busy stays high through it.
        if (rem_q == '0) begin
          state_d = IDLE;
        end else if (abort) begin
          rem_d  = '0;
          done_d = 1'b1;
        end else if (div_q == '0) begin
          // Gray-code step: forward 00->01->11->10, reverse the opposite way.
          if (dir_q) begin
            a_d   = b_q;
            b_d   = ~a_q;
            pos_d = pos_q + POS_WIDTH'(1);
          end else begin
            a_d   = ~b_q;
            b_d   = a_q;
            pos_d = pos_q - POS_WIDTH'(1);
          end
          rem_d = rem_q - CNT_WIDTH'(1);
          div_d = period_q - DIV_WIDTH'(1);
          if (rem_q == CNT_WIDTH'(1)) done_d = 1'b1;
        end else begin
          div_d = div_q - DIV_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      div_q    <= '0;
      period_q <= DIV_WIDTH'(1);
      dir_q    <= 1'b0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      pos_q    <= '0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      pos_q    <= pos_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
    end
  end

`ifdef QENC_INDEX_EN
  logic z_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) z_q <= 1'b1;
    else     z_q <= (pos_d == '0);
  end

  assign enc_z = z_q;
`endif

  assign enc_a     = a_q;
  assign enc_b     = b_q;
  assign position  = pos_q;
  assign done      = done_q;
  assign busy      = (state_q == RUN);
  assign cmd_ready = (state_q == IDLE);

endmodule
